// File: rtl/ptr_fe_feeder_pkg.sv
// Shared constants for the paper-tape front-end feeder: register map,
// STATUS bit positions and the delivery FSM encoding.
package ptr_fe_feeder_pkg;

    localparam logic [1:0] FE_DATA    = 2'd0;
    localparam logic [1:0] FE_CTRL    = 2'd1;
    localparam logic [1:0] FE_LOWMARK = 2'd2;
    localparam logic [1:0] FE_DEPTH   = 2'd3;

    localparam int ST_EMPTY   = 16;
    localparam int ST_FULL    = 17;
    localparam int ST_OVF     = 18;
    localparam int ST_STARVED = 19;
    localparam int ST_IRQEN   = 20;
    localparam int ST_BUSY    = 21;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_IRQEN = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } fe_state_e;

endpackage

// File: rtl/ptr_fe_feeder_fe_fifo.sv
// Single-clock byte FIFO with show-ahead head, flush, and a level counter
// one bit wider than the pointers so that full and empty are distinct.
module fe_fifo #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [7:0]    o_head,
    output logic [AW:0]   o_level,
    output logic          o_empty,
    output logic          o_full
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            r_level <= r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/ptr_fe_feeder.sv
// Tape-image feeder: host fills a byte FIFO over Avalon; each reader request
// is answered with exactly one ptr_write strobe carrying the next frame.
module ptr_fe_feeder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        irq,
    input  logic        fe_data_rq,
    output logic        ptr_write,
    output logic [31:0] ptr_writedata
);
    import ptr_fe_feeder_pkg::*;

    fe_state_e   r_state, w_state_nxt;
    logic [31:0] r_wdata, r_readdata, w_rd_mux, w_status;
    logic [AW:0] r_lowmark, w_level;
    logic        r_irq, r_irq_en, r_ovf, r_starved;
    logic        w_pop, w_starve, w_empty, w_full;
    logic        w_data_wr, w_ctrl_wr, w_low_wr, w_flush;
    logic [7:0]  w_head;
    logic        w_unused_wdata;

    assign w_data_wr      = s_write & (s_address == FE_DATA);
    assign w_ctrl_wr      = s_write & (s_address == FE_CTRL);
    assign w_low_wr       = s_write & (s_address == FE_LOWMARK);
    assign w_flush        = w_ctrl_wr & s_writedata[CTRL_FLUSH];
    assign w_unused_wdata = ^s_writedata[31:8];

    fe_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_data_wr),
        .i_din   (s_writedata[7:0]),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_level (w_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // HOLD waits for the request to fall so a stale level cannot double-deliver.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_starve    = 1'b0;
        case (r_state)
            S_IDLE: if (fe_data_rq) begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_starve    = 1'b1;
                end
            end
            S_SEND:  w_state_nxt = S_HOLD;
            S_HOLD:  if (!fe_data_rq) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_status             = '0;
        w_status[AW:0]       = w_level;
        w_status[ST_EMPTY]   = w_empty;
        w_status[ST_FULL]    = w_full;
        w_status[ST_OVF]     = r_ovf;
        w_status[ST_STARVED] = r_starved;
        w_status[ST_IRQEN]   = r_irq_en;
        w_status[ST_BUSY]    = (r_state != S_IDLE);
        case (s_address)
            FE_CTRL:    w_rd_mux = w_status;
            FE_LOWMARK: w_rd_mux = 32'(r_lowmark);
            FE_DEPTH:   w_rd_mux = 32'(DEPTH);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdata    <= '0;
            r_readdata <= '0;
            r_lowmark  <= '0;
            r_irq      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
            r_starved  <= 1'b0;
        end else begin
            if (w_pop) r_wdata <= {24'b0, w_head};
            if (w_ctrl_wr) begin
                if (s_writedata[CTRL_CLR]) begin
                    r_ovf     <= 1'b0;
                    r_starved <= 1'b0;
                end
                r_irq_en <= s_writedata[CTRL_IRQEN];
            end
            // New events are set after the clear so they are never lost.
            if (w_data_wr & w_full & ~w_pop) r_ovf <= 1'b1;
            if (w_starve) r_starved <= 1'b1;
            if (w_low_wr) r_lowmark <= s_writedata[AW:0];
            r_irq <= r_irq_en & (w_level <= r_lowmark);
            if (s_read) r_readdata <= w_rd_mux;
        end
    end

    assign ptr_write     = (r_state == S_SEND);
    assign ptr_writedata = r_wdata;
    assign s_readdata    = r_readdata;
    assign irq           = r_irq;

endmodule

// File: tb/tb_ptr_fe_feeder.sv
// Self-checking bench for ptr_fe_feeder: register vector table, delivery
// scoreboard fed by host pushes and drained by observed ptr_write strobes.
module tb_ptr_fe_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  s_address = '0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic        irq;
    logic        fe_data_rq = 1'b0;
    logic        ptr_write;
    logic [31:0] ptr_writedata;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        string       name;
        logic        do_wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[9];

    ptr_fe_feeder #(.DEPTH(64), .AW(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .irq           (irq),
        .fe_data_rq    (fe_data_rq),
        .ptr_write     (ptr_write),
        .ptr_writedata (ptr_writedata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every strobe must deliver the oldest frame the host pushed.
    always @(negedge clk) begin
        if (!reset && ptr_write) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got 0x%08h with nothing queued", ptr_writedata);
            end else begin
                chk("frame", ptr_writedata, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_write = 1'b1;
        tick();
        s_write = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        host_write(2'd0, {24'b0, b});
        if (exp_q.size() < 64) exp_q.push_back(b);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        s_address = a; s_read = 1'b1;
        tick();
        s_read = 1'b0;
        chk(name, s_readdata, exp);
    endtask

    task automatic request(input int k, output int delta);
        int p0;
        p0 = pulses;
        fe_data_rq = 1'b1;
        repeat (k) tick();
        fe_data_rq = 1'b0;
        tick();
        tick();
        delta = pulses - p0;
    endtask

    initial begin
        int d;
        int p0;
        vt[0] = '{"lowmark_5",    1'b1, 2'd2, 32'h0000_0005, 2'd2, 32'h0000_0005};
        vt[1] = '{"lowmark_7f",   1'b1, 2'd2, 32'h0000_007F, 2'd2, 32'h0000_007F};
        vt[2] = '{"lowmark_trunc",1'b1, 2'd2, 32'hFFFF_FF83, 2'd2, 32'h0000_0003};
        vt[3] = '{"addr3_ignored",1'b1, 2'd3, 32'h0000_0055, 2'd2, 32'h0000_0003};
        vt[4] = '{"depth_read",   1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_0040};
        vt[5] = '{"data_read0",   1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_0000};
        vt[6] = '{"irq_en_set",   1'b1, 2'd1, 32'h0000_0004, 2'd1, 32'h0011_0000};
        vt[7] = '{"irq_en_clr",   1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0001_0000};
        vt[8] = '{"lowmark_0",    1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ptr_write", {31'b0, ptr_write}, 32'h0);
        chk("rst_ptr_wdata", ptr_writedata, 32'h0);
        chk("rst_readdata", s_readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick();
        rd_chk("rst_status", 2'd1, 32'h0001_0000);

        for (int i = 0; i < 9; i++) begin
            if (vt[i].do_wr) host_write(vt[i].wa, vt[i].wd);
            rd_chk(vt[i].name, vt[i].ra, vt[i].exp);
        end

        // Two frames, first request checked cycle by cycle.
        push(8'h81);
        push(8'h3F);
        rd_chk("level2", 2'd1, 32'h0000_0002);
        p0 = pulses;
        fe_data_rq = 1'b1;
        @(negedge clk) chk("lat_N", {31'b0, ptr_write}, 32'h0);
        tick();
        @(negedge clk) chk("lat_N1", {31'b0, ptr_write}, 32'h1);
        chk("lat_N1_data", ptr_writedata, 32'h81);
        tick();
        fe_data_rq = 1'b0;
        @(negedge clk) chk("lat_N2", {31'b0, ptr_write}, 32'h0);
        tick();
        tick();
        chk("one_pulse_a", pulses - p0, 1);
        rd_chk("level1", 2'd1, 32'h0000_0001);
        chk("wdata_hold", ptr_writedata, 32'h81);
        request(2, d);
        chk("one_pulse_b", d, 1);
        rd_chk("level0", 2'd1, 32'h0001_0000);

        // Long request level must not re-deliver.
        push(8'h55);
        push(8'hAA);
        request(10, d);
        chk("long_rq_pulses", d, 1);
        request(3, d);
        chk("rearm_pulses", d, 1);

        request(3, d);
        chk("empty_rq_pulses", d, 0);
        rd_chk("starved_set", 2'd1, 32'h0009_0000);
        host_write(2'd1, 32'h2);
        rd_chk("starved_clr", 2'd1, 32'h0001_0000);

        for (int i = 0; i < 65; i++) push(8'(i + 1));
        rd_chk("full_ovf", 2'd1, 32'h0006_0040);
        host_write(2'd1, 32'h2);
        rd_chk("ovf_clr", 2'd1, 32'h0002_0040);
        p0 = pulses;
        s_address = 2'd0; s_writedata = 32'hEE; s_write = 1'b1; fe_data_rq = 1'b1;
        tick();
        s_write = 1'b0;
        exp_q.push_back(8'hEE);
        tick();
        fe_data_rq = 1'b0;
        tick();
        tick();
        chk("push_pop_full_pulse", pulses - p0, 1);
        rd_chk("push_pop_full", 2'd1, 32'h0002_0040);
        for (int i = 0; i < 64; i++) request(2, d);
        chk("drain_queue_left", exp_q.size(), 0);
        rd_chk("drain_empty", 2'd1, 32'h0001_0000);

        // Low-watermark interrupt.
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        host_write(2'd2, 32'h2);
        host_write(2'd1, 32'h4);
        tick();
        tick();
        chk("irq_lvl4", {31'b0, irq}, 32'h0);
        request(2, d);
        request(2, d);
        chk("irq_lvl2", {31'b0, irq}, 32'h1);
        push(8'h15);
        tick();
        tick();
        chk("irq_lvl3", {31'b0, irq}, 32'h0);
        host_write(2'd1, 32'h5);
        exp_q.delete();
        tick();
        tick();
        chk("irq_flush", {31'b0, irq}, 32'h1);
        rd_chk("flush_status", 2'd1, 32'h0011_0000);

        // Reset in the middle of a strobe drops it asynchronously.
        push(8'h5A);
        fe_data_rq = 1'b1;
        tick();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_abort", {31'b0, ptr_write}, 32'h0);
        fe_data_rq = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_irq", {31'b0, irq}, 32'h0);
        rd_chk("rst2_status", 2'd1, 32'h0001_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
